// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, operands shifted LSB first through it,
// with a Start/Busy/Done handshake and registered result outputs.

module full_adder (
    input  logic A_In,
    input  logic B_In,
    input  logic Carry_In,
    output logic Sum_Out,
    output logic Carry_Out
);
    assign Sum_Out   = A_In ^ B_In ^ Carry_In;
    assign Carry_Out = (A_In & B_In) | (Carry_In & (A_In ^ B_In));
endmodule

module serial_adder #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clock_In,
    input  logic                  Reset_n_In,
    input  logic                  Start_In,
    input  logic [DATA_WIDTH-1:0] Data_A_In,
    input  logic [DATA_WIDTH-1:0] Data_B_In,
    input  logic                  Carry_In,
    output logic                  Busy_Out,
    output logic                  Done_Out,
    output logic [DATA_WIDTH-1:0] Sum_Out,
    output logic                  Carry_Out
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_sh_q, a_sh_d;
    logic [DATA_WIDTH-1:0] b_sh_q, b_sh_d;
    logic [DATA_WIDTH-1:0] s_sh_q, s_sh_d;
    logic                  c_q, c_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic                  carry_q, carry_d;

    logic fa_sum;
    logic fa_carry;

    full_adder u_full_adder (
        .A_In      (a_sh_q[0]),
        .B_In      (b_sh_q[0]),
        .Carry_In  (c_q),
        .Sum_Out   (fa_sum),
        .Carry_Out (fa_carry)
    );

    always_comb begin
        // NOTE: every *_d defaults to its *_q first, so no path through the case leaves a latch.
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        c_d     = c_q;
        count_d = count_q;
        sum_d   = sum_q;
        carry_d = carry_q;

        case (state_q)
            IDLE, DONE: begin
                if (Start_In) begin
                    a_sh_d  = Data_A_In;
                    b_sh_d  = Data_B_In;
                    c_d     = Carry_In;
                    count_d = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                // Index assignment rather than a concatenation keeps DATA_WIDTH=1 legal.
                s_sh_d  = s_sh_q >> 1;
                s_sh_d[DATA_WIDTH-1] = fa_sum;
                c_d     = fa_carry;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(DATA_WIDTH - 1)) begin
                    sum_d   = s_sh_d;
                    carry_d = fa_carry;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge Clock_In) begin
        if (!Reset_n_In) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            c_q     <= 1'b0;
            count_q <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            c_q     <= c_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign Busy_Out  = (state_q == RUN);
    assign Done_Out  = (state_q == DONE);
    assign Sum_Out   = sum_q;
    assign Carry_Out = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at widths 8, 13 and 1, checked against
// an arithmetic reference (A + B + Cin) and the handshake timing rules.

module tb_serial_adder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start [3];
    logic [63:0] a_in  [3];
    logic [63:0] b_in  [3];
    logic        cin   [3];
    logic        busy  [3];
    logic        done  [3];
    logic        cout  [3];
    logic [7:0]  sum8;
    logic [12:0] sum13;
    logic [0:0]  sum1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.DATA_WIDTH(8)) dut8 (
        .Clock_In(clk), .Reset_n_In(rst_n), .Start_In(start[0]),
        .Data_A_In(a_in[0][7:0]), .Data_B_In(b_in[0][7:0]), .Carry_In(cin[0]),
        .Busy_Out(busy[0]), .Done_Out(done[0]), .Sum_Out(sum8), .Carry_Out(cout[0])
    );

    serial_adder #(.DATA_WIDTH(13)) dut13 (
        .Clock_In(clk), .Reset_n_In(rst_n), .Start_In(start[1]),
        .Data_A_In(a_in[1][12:0]), .Data_B_In(b_in[1][12:0]), .Carry_In(cin[1]),
        .Busy_Out(busy[1]), .Done_Out(done[1]), .Sum_Out(sum13), .Carry_Out(cout[1])
    );

    serial_adder #(.DATA_WIDTH(1)) dut1 (
        .Clock_In(clk), .Reset_n_In(rst_n), .Start_In(start[2]),
        .Data_A_In(a_in[2][0:0]), .Data_B_In(b_in[2][0:0]), .Carry_In(cin[2]),
        .Busy_Out(busy[2]), .Done_Out(done[2]), .Sum_Out(sum1), .Carry_Out(cout[2])
    );

    function automatic int width_of(int i);
        case (i)
            0:       return 8;
            1:       return 13;
            default: return 1;
        endcase
    endfunction

    function automatic logic [63:0] sum_of(int i);
        logic [63:0] r;
        case (i)
            0:       r = {56'd0, sum8};
            1:       r = {51'd0, sum13};
            default: r = {63'd0, sum1};
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts one addition on DUT i, follows it to its Done cycle and checks the
    // Busy length, Done pulse, result, and that outputs held steady meanwhile.
    // Returns in the Done cycle, one time unit after the result edge.
    task automatic run_op(input int i, input logic [63:0] a, input logic [63:0] b,
                          input logic c, input bit hold, input bit poke, output time t_done);
        int          w;
        int          n;
        bit          held;
        logic [63:0] mask;
        logic [63:0] full;
        logic [63:0] prev_s;
        logic        prev_c;
        w      = width_of(i);
        mask   = (64'd1 << w) - 64'd1;
        full   = (a & mask) + (b & mask) + {63'd0, c};
        prev_s = sum_of(i);
        prev_c = cout[i];

        start[i] = 1'b1;
        a_in[i]  = a;
        b_in[i]  = b;
        cin[i]   = c;
        step();
        if (!hold) start[i] = 1'b0;

        n    = 0;
        held = 1'b1;
        while (busy[i] === 1'b1 && n < 200) begin
            if (sum_of(i) !== prev_s || cout[i] !== prev_c) held = 1'b0;
            if (poke && n == 3) begin
                a_in[i]  = '1;
                b_in[i]  = '1;
                start[i] = 1'b1;
            end else if (poke && n == 4) begin
                start[i] = 1'b0;
            end
            n++;
            step();
        end
        t_done = $time;

        check($sformatf("w%0d_busy_cycles", w), 64'(n), 64'(w));
        check($sformatf("w%0d_done", w), {63'd0, done[i]}, 64'd1);
        check($sformatf("w%0d_sum a=%0h b=%0h c=%0d", w, a & mask, b & mask, c), sum_of(i), full & mask);
        check($sformatf("w%0d_carry a=%0h b=%0h c=%0d", w, a & mask, b & mask, c), {63'd0, cout[i]}, (full >> w) & 64'd1);
        check($sformatf("w%0d_held_during_run", w), {63'd0, held}, 64'd1);
    endtask

    initial begin
        time t1;
        time t2;
        bit  saw_done;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            a_in[i]  = '0;
            b_in[i]  = '0;
            cin[i]   = 1'b0;
        end
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_busy_%0d", i),  {63'd0, busy[i]}, 64'd0);
            check($sformatf("reset_done_%0d", i),  {63'd0, done[i]}, 64'd0);
            check($sformatf("reset_sum_%0d", i),   sum_of(i), 64'd0);
            check($sformatf("reset_carry_%0d", i), {63'd0, cout[i]}, 64'd0);
        end
        rst_n = 1'b1;
        step();

        // Basic addition, then the result must persist through idle cycles.
        run_op(0, 64'h5A, 64'h3C, 1'b0, 1'b0, 1'b0, t1);
        for (int k = 0; k < 5; k++) step();
        check("idle_hold_sum",   sum_of(0), 64'h96);
        check("idle_hold_carry", {63'd0, cout[0]}, 64'd0);
        check("idle_done_low",   {63'd0, done[0]}, 64'd0);
        check("idle_busy_low",   {63'd0, busy[0]}, 64'd0);

        // Carry-out boundaries; the second Start is accepted from DONE.
        run_op(0, 64'hFF, 64'h01, 1'b0, 1'b0, 1'b0, t1);
        run_op(0, 64'hFF, 64'hFF, 1'b1, 1'b0, 1'b0, t1);
        step();

        // Start held high: back-to-back operations, Done pulses 9 cycles apart.
        run_op(0, 64'h01, 64'h01, 1'b0, 1'b1, 1'b0, t1);
        run_op(0, 64'h80, 64'h80, 1'b0, 1'b1, 1'b0, t2);
        start[0] = 1'b0;
        check("b2b_done_spacing", 64'(t2 - t1), 64'd90);
        step();
        check("b2b_end_busy", {63'd0, busy[0]}, 64'd0);
        check("b2b_end_done", {63'd0, done[0]}, 64'd0);

        // Start and operands disturbed mid-RUN must not affect the result.
        run_op(0, 64'h10, 64'h20, 1'b0, 1'b0, 1'b1, t1);
        step();
        check("poke_single_done", {63'd0, done[0]}, 64'd0);
        check("poke_busy_low",    {63'd0, busy[0]}, 64'd0);

        // Reset in RUN cycle 4 aborts the operation and clears results.
        start[0] = 1'b1;
        a_in[0]  = 64'h0F;
        b_in[0]  = 64'h0F;
        cin[0]   = 1'b0;
        step();
        start[0] = 1'b0;
        for (int k = 0; k < 3; k++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort_busy",  {63'd0, busy[0]}, 64'd0);
        check("abort_done",  {63'd0, done[0]}, 64'd0);
        check("abort_sum",   sum_of(0), 64'd0);
        check("abort_carry", {63'd0, cout[0]}, 64'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (done[0] !== 1'b0 || busy[0] !== 1'b0) saw_done = 1'b1;
            step();
        end
        check("abort_no_done", {63'd0, saw_done}, 64'd0);
        run_op(0, 64'h0F, 64'h0F, 1'b0, 1'b0, 1'b0, t1);
        step();

        // Single-bit width.
        run_op(2, 64'd1, 64'd1, 1'b1, 1'b0, 1'b0, t1);
        step();
        run_op(2, 64'd1, 64'd0, 1'b0, 1'b0, 1'b0, t1);
        step();

        // Random sweeps.
        for (int k = 0; k < 500; k++)
            run_op(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0, 1'b0, t1);
        step();
        for (int k = 0; k < 500; k++)
            run_op(1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0, 1'b0, t1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder that computes A + B + Cin one bit per clock, LSB first.
- Uses a single instance of the team's 1-bit Full_Adder cell. The block drives that cell's three inputs from operand shift registers and a carry flip-flop, and consumes its Carry_Out/Sum_Out.
- Intended as the area-minimal adder for low-throughput datapaths. A Start/Busy/Done handshake lets a controller sequence operations.

Parameters:
DATA_WIDTH, 8, operand and sum width in bits; legal range 1 to 64.

Ports:
Clock_In  input  1  single clock; all state updates on its rising edge
Reset_n_In  input  1  synchronous, active-low reset
Start_In  input  1  request a new addition; sampled only in IDLE or DONE
Data_A_In  input  DATA_WIDTH  operand A, captured when Start is accepted
Data_B_In  input  DATA_WIDTH  operand B, captured when Start is accepted
Carry_In  input  1  carry-in, captured when Start is accepted
Busy_Out  input/output: output  1  high while bits are being processed (RUN)
Done_Out  output  1  one-cycle pulse: result registers just updated
Sum_Out  output  DATA_WIDTH  registered sum of the last completed operation
Carry_Out  output  1  registered carry-out of the last completed operation

Behaviour:
- Reset (Reset_n_In low at a rising edge) forces:
  - state IDLE
  - Busy_Out=0, Done_Out=0, Sum_Out=0, Carry_Out=0
  - internal shift registers, carry flip-flop and bit counter all 0.
- Reset wins over every other event. A reset during RUN aborts the operation: no Done pulse is issued, and Sum_Out/Carry_Out are zeroed.
- The FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - Start_In=1 at edge k: load A_sh<=Data_A_In, B_sh<=Data_B_In, C<=Carry_In, count<=0; go to RUN.
  - Start_In=0: stay in IDLE.
- RUN, at each edge:
  - The Full_Adder inputs are A_sh[0], B_sh[0] and C.
  - Shift A_sh and B_sh right by 1.
  - Shift the sum bit into the MSB of the sum shift register S_sh (S_sh shifts right).
  - C <= Full_Adder Carry_Out; count <= count+1.
- RUN exit and result capture:
  - On the edge where count==DATA_WIDTH-1, the final bit is processed and the state goes to DONE.
  - On that same edge, Sum_Out <= final S_sh value (including this bit) and Carry_Out <= final carry.
- Start_In is ignored throughout RUN, and operand inputs are don't-care during RUN.
- DONE lasts exactly one cycle, with Done_Out=1:
  - Start_In=1: accepted exactly as in IDLE; next state is RUN, giving back-to-back operation with no idle gap.
  - Start_In=0: next state is IDLE.
- Output decode:
  - Busy_Out=1 iff state==RUN.
  - Done_Out=1 iff state==DONE.
  - Both are registered state decodes with no combinational path from inputs.
- Latency: with Start accepted at edge k, Busy_Out is high for exactly DATA_WIDTH cycles (after edges k..k+DATA_WIDTH-1).
  - Sum_Out/Carry_Out update at edge k+DATA_WIDTH.
  - Done_Out is high in the cycle following edge k+DATA_WIDTH.
  - Throughput is one operation per DATA_WIDTH+1 cycles.
- Sum_Out/Carry_Out hold the last result until the next completion or a reset. They never show partial sums.
- Arithmetic: {Carry_Out, Sum_Out} = Data_A_In + Data_B_In + Carry_In, exact over DATA_WIDTH+1 bits, unsigned. Two's-complement overflow is not flagged.
- Counter width is clog2(DATA_WIDTH+1). For DATA_WIDTH=1, RUN lasts exactly one cycle; the counter never wraps.

Test Plan:
- W=8: A=0x5A, B=0x3C, Cin=0, Start one cycle → Busy high 8 cycles, then Done pulse 1 cycle, Sum_Out=0x96, Carry_Out=0; outputs unchanged until next completion.
- W=8: A=0xFF, B=0x01, Cin=0 → Sum_Out=0x00, Carry_Out=1; then A=0xFF, B=0xFF, Cin=1 → Sum_Out=0xFF, Carry_Out=1.
- Start held high continuously with new operands on each DONE cycle (0x01+0x01, then 0x80+0x80) → back-to-back results 0x02/0 and 0x00/1, Done pulses exactly 9 cycles apart, Busy low only during DONE cycles.
- Start pulsed and operands changed mid-RUN (A=0x10+B=0x20, then A=0xFF during RUN) → ignored, result 0x30/0, single Done pulse.
- Reset_n_In low for 1 cycle at RUN cycle 4 of 0x0F+0x0F → next cycle Busy=0, Done=0, Sum_Out=0, Carry_Out=0, IDLE; no Done ever issued for that operation; new Start works normally.
- W=1: A=1, B=1, Cin=1 → Busy high 1 cycle, Sum_Out=1, Carry_Out=1; 500-vector random sweep at W=8 and W=13 against a reference sum model.
